mem_stage: RTL

- MEM pipeline stage of the 5-stage LoongArch core; upstream end of the ms_to_ws interface that feeds the WB stage.
- Latches the EX→MEM bus and consumes the synchronous data-SRAM read data.
- Performs load byte/half select and sign/zero extension, then drives the MEM→WB bus and the MEM→ID forward bus.
- Holds a one-entry read-data skid register, so load data survives WB backpressure after the SRAM output has moved on.

---
 rtl/mem_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MEM stage: latches the EX->MEM bus, extends load data from the data SRAM and drives
// the MEM->WB and MEM->ID forward buses. A one-entry skid register keeps load data alive under WB backpressure.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ms_stall,
  input  logic                       ms_flush,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [37:0]                ms_to_ds_forward_bus
);

  logic                       vld_p0;
  logic                       first_p0;
  logic                       buf_vld_p0;
  logic [31:0]                buf_data_p0;
  logic [ES_TO_MS_BUS_WD-1:0] bus_p0;

  logic        ms_ready_go;
  logic        leave;
  logic        res_from_mem;
  logic [2:0]  ld_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] mem_word;
  logic [31:0] final_result;
  logic        fwd_en;

  // Byte/half select from the low address bits, then sign or zero extension by ld_op.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  addr,
                                           input logic [2:0]  op);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    shifted = word >> {addr, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = addr[1] ? word[31:16] : word[15:0];
    case (op)
      3'b001:  load_ext = 32'(byte_s);
      3'b010:  load_ext = 32'(half_s);
      3'b011:  load_ext = {24'd0, byte_s};
      3'b100:  load_ext = {16'd0, half_s};
      default: load_ext = word;
    endcase
  endfunction

  assign res_from_mem = bus_p0[73];
  assign ld_op        = bus_p0[72:70];
  assign gr_we        = bus_p0[69];
  assign dest         = bus_p0[68:64];
  assign alu_result   = bus_p0[63:32];
  assign pc           = bus_p0[31:0];

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = (!vld_p0 || (ms_ready_go && ws_allowin)) && !ms_stall;
  assign ms_to_ws_valid = vld_p0 && ms_ready_go;
  assign leave          = ms_to_ws_valid && ws_allowin;

  // Stage p0 register: instruction held in MEM plus the skid copy of its load data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0      <= 1'b0;
      bus_p0      <= '0;
      first_p0    <= 1'b0;
      buf_vld_p0  <= 1'b0;
      buf_data_p0 <= '0;
    end else if (ms_flush) begin
      vld_p0     <= 1'b0;
      bus_p0     <= '0;
      first_p0   <= 1'b0;
      buf_vld_p0 <= 1'b0;
    end else begin
      if (ms_allowin)
        vld_p0 <= es_to_ms_valid;
      else if (leave)
        vld_p0 <= 1'b0;
      if (es_to_ms_valid && ms_allowin)
        bus_p0 <= es_to_ms_bus;
      first_p0 <= es_to_ms_valid && ms_allowin;
      // SRAM data is only valid in the entry cycle; keep a copy if WB is not taking it now.
      if (leave)
        buf_vld_p0 <= 1'b0;
      else if (first_p0 && vld_p0 && res_from_mem && !ws_allowin) begin
        buf_vld_p0  <= 1'b1;
        buf_data_p0 <= data_sram_rdata;
      end
    end
  end

  // Combinational result path out of p0.
  assign mem_word     = buf_vld_p0 ? buf_data_p0 : data_sram_rdata;
  assign final_result = res_from_mem ? load_ext(mem_word, alu_result[1:0], ld_op) : alu_result;
  assign fwd_en       = vld_p0 && gr_we && (dest != 5'd0);

  assign ms_to_ws_bus         = {gr_we, dest, final_result, pc};
  assign ms_to_ds_forward_bus = {fwd_en, dest, final_result};

endmodule
